ysyx_23060337_ifu: RTL and testbench

//   Instruction fetch stage, directly upstream of the decode stage. Holds the PC and issues

---
 rtl/ysyx_23060337_pkg.sv | 30 +++
 rtl/ysyx_23060337_ifu_if.sv | 30 +++
 rtl/ysyx_23060337_pc_reg.sv | 33 +++
 rtl/ysyx_23060337_ifu.sv | 136 +++++++++++++
 tb/tb_ysyx_23060337_ifu.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060337_pkg.sv
// Shared types and constants for the ysyx_23060337 instruction fetch unit.
package ysyx_23060337_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned STATE_W = 3;

  localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [INST_W-1:0] PC_STEP      = 32'd4;

  typedef enum logic [STATE_W-1:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_DROP  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_e;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/ysyx_23060337_ifu_if.sv
// Fetch-unit bus bundle: imem request/response, execute redirect and decode output.
interface ysyx_23060337_ifu_if;
  import ysyx_23060337_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [INST_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [INST_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           out_ready
  );

endinterface

// File: rtl/ysyx_23060337_pc_reg.sv
// Program counter register with next-pc select (hold / +4 / redirect / pending target).
module ysyx_23060337_pc_reg
  import ysyx_23060337_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           sel,
  input  logic [INST_W-1:0] redirect_pc,
  input  logic [INST_W-1:0] pend_pc,
  output logic [INST_W-1:0] pc
);

  logic [INST_W-1:0] pc_d;

  // Sequential step wraps naturally at 2^32.
  always_comb begin
    pc_d = pc;
    case (sel)
      PC_INC:   pc_d = pc + PC_STEP;
      PC_REDIR: pc_d = redirect_pc;
      PC_PEND:  pc_d = pend_pc;
      default:  pc_d = pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_d;
  end

endmodule

// File: rtl/ysyx_23060337_ifu.sv
// Instruction fetch: single-outstanding imem reads, one-entry output buffer to decode.
// Optional misaligned-redirect trap enabled by YSYX_23060337_IFU_ALIGN_CHK_EN.
module ysyx_23060337_ifu
  import ysyx_23060337_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic                clk,
  input logic                rst,
  ysyx_23060337_ifu_if.master bus
);

  ifu_state_e        state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [INST_W-1:0] pend_pc_q, pend_pc_d;
  logic              out_valid_q, out_valid_d;
  fetch_pkt_t        out_q, out_d;
  pc_sel_e           pc_sel;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] redir_tgt;
  logic              redir_bad;

`ifdef YSYX_23060337_IFU_ALIGN_CHK_EN
  assign redir_bad       = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redir_tgt       = bus.redirect_pc;
  assign bus.fetch_fault = (state_q == S_FAULT);
`else
  logic unused_redir_lo;
  assign unused_redir_lo = ^bus.redirect_pc[1:0];
  assign redir_bad       = 1'b0;
  assign redir_tgt       = {bus.redirect_pc[INST_W-1:2], 2'b00};
  assign bus.fetch_fault = 1'b0;
`endif

  ysyx_23060337_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .sel         (pc_sel),
    .redirect_pc (redir_tgt),
    .pend_pc     (pend_pc_q),
    .pc          (pc)
  );

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = out_q.pc;
  assign bus.out_inst       = out_q.inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  // Redirects are parked in pend_pc while a request is in flight so the address never moves mid-handshake.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    pc_sel       = PC_HOLD;

    if (redir_bad && state_q != S_FAULT) begin
      state_d      = S_FAULT;
      out_valid_d  = 1'b0;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (bus.redirect_valid) begin
            pend_pc_d    = redir_tgt;
            pend_valid_d = 1'b1;
          end
          if (bus.imem_req_ready)
            state_d = (bus.redirect_valid || pend_valid_q) ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            if (bus.imem_rsp_valid) begin
              pc_sel       = PC_REDIR;
              pend_valid_d = 1'b0;
              state_d      = S_REQ;
            end else begin
              pend_pc_d    = redir_tgt;
              pend_valid_d = 1'b1;
              state_d      = S_DROP;
            end
          end else if (bus.imem_rsp_valid) begin
            out_d.pc    = pc;
            out_d.inst  = bus.imem_rsp_data;
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
        S_DROP: begin
          if (bus.imem_rsp_valid) begin
            pc_sel       = bus.redirect_valid ? PC_REDIR : PC_PEND;
            pend_valid_d = 1'b0;
            state_d      = S_REQ;
          end else if (bus.redirect_valid) begin
            pend_pc_d = redir_tgt;
          end
        end
        S_HOLD: begin
          if (bus.redirect_valid) begin
            pc_sel      = PC_REDIR;
            out_valid_d = 1'b0;
            state_d     = S_REQ;
          end else if (bus.out_ready) begin
            pc_sel      = PC_INC;
            out_valid_d = 1'b0;
            state_d     = S_REQ;
          end
        end
        S_FAULT: begin
          out_valid_d  = 1'b0;
          pend_valid_d = 1'b0;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060337_ifu.sv
// Directed bench for ysyx_23060337_ifu with a latency-configurable imem responder.
module tb_ysyx_23060337_ifu;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;
  int   rsp_lat;
  int   rcnt;
  int   n;
  logic [31:0] saved_addr;

  ysyx_23060337_ifu_if bus ();

  ysyx_23060337_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; imem answers rsp_lat cycles after acceptance; redirect is a one-cycle pulse.
  task automatic step();
    logic acc;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    if (acc) saved_addr = bus.imem_req_addr;
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    if (acc) rcnt = rsp_lat;
    if (rcnt != 0) begin
      rcnt--;
      if (rcnt == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = inst_of(saved_addr);
      end
    end
  endtask

  task automatic wait_out(input int max, output int cycles);
    cycles = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bus.out_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    rsp_lat = 1; rcnt = 0; saved_addr = '0;
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    rst = 1'b0;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rst_req_addr", bus.imem_req_addr, 32'h8000_0000);

    // 1: sequential stream
    wait_out(8, n);
    chk("t1_lat0", 32'(n), 32'd2);
    chk("t1_pc0", bus.out_pc, 32'h8000_0000);
    chk("t1_inst0", bus.out_inst, inst_of(32'h8000_0000));
    for (int k = 1; k <= 2; k++) begin
      wait_out(8, n);
      chk("t1_gap", 32'(n), 32'd3);
      chk("t1_pc", bus.out_pc, 32'h8000_0000 + 32'(4 * k));
      chk("t1_inst", bus.out_inst, inst_of(32'h8000_0000 + 32'(4 * k)));
    end

    // 2: decode back-pressure
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_pc", bus.out_pc, 32'h8000_0008);
      chk("t2_inst", bus.out_inst, inst_of(32'h8000_0008));
      chk("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t2_next_req", 32'(bus.imem_req_valid), 32'd1);
    chk("t2_next_addr", bus.imem_req_addr, 32'h8000_000C);
    chk("t2_out_clr", 32'(bus.out_valid), 32'd0);

    // 3: redirect while waiting for the response
    rsp_lat = 2;
    step();
    chk("t3_wait_nout", 32'(bus.out_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_1000;
    step();
    chk("t3_drop_noreq", 32'(bus.imem_req_valid), 32'd0);
    step();
    chk("t3_req_addr", bus.imem_req_addr, 32'h8000_1000);
    chk("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("t3_stale_hidden", 32'(bus.out_valid), 32'd0);
    rsp_lat = 1;
    wait_out(8, n);
    chk("t3_lat", 32'(n), 32'd2);
    chk("t3_pc", bus.out_pc, 32'h8000_1000);
    chk("t3_inst", bus.out_inst, inst_of(32'h8000_1000));

    // 4: redirect during a stalled request
    step();
    bus.imem_req_ready = 1'b0;
    chk("t4_addr0", bus.imem_req_addr, 32'h8000_1004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_2000;
    step();
    chk("t4_addr1", bus.imem_req_addr, 32'h8000_1004);
    chk("t4_valid1", 32'(bus.imem_req_valid), 32'd1);
    step();
    chk("t4_addr2", bus.imem_req_addr, 32'h8000_1004);
    bus.imem_req_ready = 1'b1;
    step();
    chk("t4_drop_noreq", 32'(bus.imem_req_valid), 32'd0);
    chk("t4_drop_nout", 32'(bus.out_valid), 32'd0);
    step();
    chk("t4_tgt_addr", bus.imem_req_addr, 32'h8000_2000);
    wait_out(8, n);
    chk("t4_lat", 32'(n), 32'd2);
    chk("t4_pc", bus.out_pc, 32'h8000_2000);

    // 5: redirect in HOLD together with out_ready
    chk("t5_held_pc", bus.out_pc, 32'h8000_2000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_3000;
    step();
    chk("t5_out_clr", 32'(bus.out_valid), 32'd0);
    chk("t5_addr", bus.imem_req_addr, 32'h8000_3000);
    wait_out(8, n);
    chk("t5_lat", 32'(n), 32'd2);
    chk("t5_pc", bus.out_pc, 32'h8000_3000);
    chk("t5_inst", bus.out_inst, inst_of(32'h8000_3000));

    // pc wrap at top of address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    chk("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
    wait_out(8, n);
    chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", bus.imem_req_addr, 32'h0000_0000);

    // 6: misaligned redirect, accepted in the same cycle
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0002;
    step();
`ifdef YSYX_23060337_IFU_ALIGN_CHK_EN
    chk("t6_fault", 32'(bus.fetch_fault), 32'd1);
    chk("t6_noreq", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_nout", 32'(bus.out_valid), 32'd0);
    repeat (3) step();
    chk("t6_fault_sticky", 32'(bus.fetch_fault), 32'd1);
    chk("t6_noreq_sticky", 32'(bus.imem_req_valid), 32'd0);
    chk("t6_nout_sticky", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    rcnt = 0;
    bus.imem_rsp_valid = 1'b0;
    #2;
    chk("t6_rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("t6_rst_req", 32'(bus.imem_req_valid), 32'd1);
    chk("t6_rst_addr", bus.imem_req_addr, 32'h8000_0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
`else
    chk("t6_nofault", 32'(bus.fetch_fault), 32'd0);
    chk("t6_drop_noreq", 32'(bus.imem_req_valid), 32'd0);
    step();
    chk("t6_aligned_addr", bus.imem_req_addr, 32'h8000_0000);
    wait_out(8, n);
    chk("t6_lat", 32'(n), 32'd2);
    chk("t6_pc", bus.out_pc, 32'h8000_0000);
    chk("t6_fault_zero", 32'(bus.fetch_fault), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
